if_fetch: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core: it owns the program counter, issues single-outstanding requests to instruction memory, and writes each fetched instruction into the IF/ID pipeline register. It drives the IF/ID register's `pc_in`, `ins_in` and `en_reg` inputs, honours ID-stage stalls by buffering a returned instruction, and squashes wrong-path fetches on EX-stage redirects by writing a NOP bubble.

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_fetch.sv | 140 ++++++++++++++
 tb/tb_if_fetch.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: NOP encoding, PC step and the
// instruction-fetch state encoding.
package mips_pkg;

    localparam logic [31:0] NOP_INS = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one request to
// instruction memory in flight, feeds the IF/ID register, buffers a returned
// instruction across ID stalls and squashes wrong-path fetches on redirects.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic        en_reg
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  tgt_reg, tgt_next;
    logic [31:0]  hold_ins_reg, hold_ins_next;
    logic [31:0]  hold_pc_reg, hold_pc_next;
    logic [31:0]  pc_plus;

    assign pc_plus = pc_reg + PC_STEP;

    // State, PC, redirect target and stall buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            tgt_reg      <= '0;
            hold_ins_reg <= '0;
            hold_pc_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            tgt_reg      <= tgt_next;
            hold_ins_reg <= hold_ins_next;
            hold_pc_reg  <= hold_pc_next;
        end
    end

    // Next-state logic and IF/ID drive; redirect beats stall and ack everywhere
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        tgt_next      = tgt_reg;
        hold_ins_next = hold_ins_reg;
        hold_pc_next  = hold_pc_reg;
        imem_req      = 1'b0;
        imem_addr     = pc_reg;
        en_reg        = 1'b0;
        pc_out        = '0;
        ins_out       = NOP_INS;

        case (state_reg)
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    en_reg        = 1'b1;
                    hold_ins_next = '0;
                    hold_pc_next  = '0;
                    if (imem_ack) begin
                        pc_next    = redirect_pc;
                        state_next = S_REQ;
                    end else begin
                        // Request still in flight: its address must stay put
                        tgt_next   = redirect_pc;
                        state_next = S_DROP;
                    end
                end else if (imem_ack) begin
                    pc_next = pc_plus;
                    if (stall) begin
                        hold_ins_next = imem_data;
                        hold_pc_next  = pc_plus;
                        state_next    = S_HOLD;
                    end else begin
                        en_reg  = 1'b1;
                        ins_out = imem_data;
                        pc_out  = pc_plus;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    en_reg        = 1'b1;
                    hold_ins_next = '0;
                    hold_pc_next  = '0;
                    pc_next       = redirect_pc;
                    state_next    = S_REQ;
                end else begin
                    ins_out = hold_ins_reg;
                    pc_out  = hold_pc_reg;
                    en_reg  = !stall;
                    if (!stall) begin
                        state_next = S_REQ;
                    end
                end
            end

            S_DROP: begin
                imem_req = 1'b1;
                if (redirect) begin
                    en_reg        = 1'b1;
                    hold_ins_next = '0;
                    hold_pc_next  = '0;
                    if (imem_ack) begin
                        pc_next    = redirect_pc;
                        state_next = S_REQ;
                    end else begin
                        tgt_next = redirect_pc;
                    end
                end else if (imem_ack) begin
                    // Wrong-path data is dropped; resume at the saved target
                    pc_next    = tgt_reg;
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_REQ;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
            en_reg   = 1'b0;
            pc_out   = '0;
            ins_out  = NOP_INS;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the fetch stage.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic        en_reg;

    int n_cmp  = 0;
    int n_fail = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .pc_out(pc_out),
        .ins_out(ins_out), .en_reg(en_reg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h1;
    endfunction

    task automatic drive(input logic r, input logic s, input logic rd,
                         input logic [31:0] rpc, input logic ack,
                         input logic [31:0] d);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        imem_ack = ack; imem_data = d;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_cmp++; if (en_reg !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en_reg); end
        n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        n_cmp++; if (ins_out !== 32'h0) begin n_fail++; $display("FAIL reset_ins_out: got %h expected 0", ins_out); end
        $display("reset: req=%b en=%b", imem_req, en_reg);
        next_cycle();
    endtask

    task automatic test_stream();
        drive(0, 0, 0, 0, 1, 32'h2001_0005);
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_addr0: got %h expected 0", imem_addr); end
        n_cmp++; if (en_reg !== 1'b1 || pc_out !== 32'h4 || ins_out !== 32'h2001_0005) begin
            n_fail++; $display("FAIL stream_w0: got en=%b pc=%h ins=%h expected 1/4/20010005", en_reg, pc_out, ins_out); end
        $display("stream: addr=%h en=%b pc_out=%h ins=%h", imem_addr, en_reg, pc_out, ins_out);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h2002_0007);
        n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL stream_addr1: got %h expected 4", imem_addr); end
        n_cmp++; if (en_reg !== 1'b1 || pc_out !== 32'h8 || ins_out !== 32'h2002_0007) begin
            n_fail++; $display("FAIL stream_w1: got en=%b pc=%h ins=%h expected 1/8/20020007", en_reg, pc_out, ins_out); end
        $display("stream: addr=%h en=%b pc_out=%h ins=%h", imem_addr, en_reg, pc_out, ins_out);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL stream_addr2: got req=%b addr=%h expected 1/8", imem_req, imem_addr); end
        $display("stream: addr=%h req=%b", imem_addr, imem_req);
    endtask

    task automatic test_stall();
        drive(0, 1, 0, 0, 1, 32'hAABB_CCDD);
        n_cmp++; if (en_reg !== 1'b0) begin n_fail++; $display("FAIL stall_ack_en: got %b expected 0", en_reg); end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            n_cmp++; if (en_reg !== 1'b0 || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got en=%b req=%b expected 0/0", i, en_reg, imem_req); end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (en_reg !== 1'b1 || ins_out !== 32'hAABB_CCDD || pc_out !== 32'hC) begin
            n_fail++; $display("FAIL stall_release: got en=%b ins=%h pc=%h expected 1/aabbccdd/c", en_reg, ins_out, pc_out); end
        $display("stall release: en=%b ins=%h pc_out=%h", en_reg, ins_out, pc_out);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            n_fail++; $display("FAIL stall_next_addr: got req=%b addr=%h expected 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_ack();
        drive(0, 0, 1, 32'h100, 1, 32'h1111_2222);
        n_cmp++; if (en_reg !== 1'b1 || ins_out !== 32'h0 || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL redir_ack_bubble: got en=%b ins=%h pc=%h expected 1/0/0", en_reg, ins_out, pc_out); end
        $display("redirect+ack: en=%b ins=%h pc_out=%h", en_reg, ins_out, pc_out);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h3333_4444);
        n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_ack_addr: got %h expected 100", imem_addr); end
        n_cmp++; if (en_reg !== 1'b1 || pc_out !== 32'h104) begin
            n_fail++; $display("FAIL redir_ack_fetch: got en=%b pc=%h expected 1/104", en_reg, pc_out); end
        next_cycle();
    endtask

    task automatic test_redirect_wait();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL wait_addr0: got %h expected 104", imem_addr); end
        next_cycle();
        drive(0, 0, 1, 32'h100, 0, 0);
        n_cmp++; if (en_reg !== 1'b1 || ins_out !== 32'h0 || imem_addr !== 32'h104) begin
            n_fail++; $display("FAIL wait_redir: got en=%b ins=%h addr=%h expected 1/0/104", en_reg, ins_out, imem_addr); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || en_reg !== 1'b0) begin
            n_fail++; $display("FAIL wait_hold_addr: got req=%b addr=%h en=%b expected 1/104/0", imem_req, imem_addr, en_reg); end
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h5555_6666);
        n_cmp++; if (imem_addr !== 32'h104 || en_reg !== 1'b0) begin
            n_fail++; $display("FAIL wait_drop_ack: got addr=%h en=%b expected 104/0", imem_addr, en_reg); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL wait_next_addr: got req=%b addr=%h expected 1/100", imem_req, imem_addr); end
        $display("redirect during wait: next addr=%h", imem_addr);
    endtask

    task automatic test_redirect_hold();
        drive(0, 1, 0, 0, 1, 32'hAABB_CCDD);
        next_cycle();
        drive(0, 1, 1, 32'h100, 0, 0);
        n_cmp++; if (en_reg !== 1'b1 || ins_out !== 32'h0 || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL hold_redir_bubble: got en=%b ins=%h pc=%h expected 1/0/0", en_reg, ins_out, pc_out); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || en_reg !== 1'b0 || ins_out === 32'hAABB_CCDD) begin
            n_fail++; $display("FAIL hold_redir_next: got req=%b addr=%h en=%b ins=%h expected 1/100/0/not-aabbccdd", imem_req, imem_addr, en_reg, ins_out); end
        $display("redirect in hold: next addr=%h", imem_addr);
    endtask

    task automatic test_reset_wait();
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 1, 32'h7777_8888);
        n_cmp++; if (imem_req !== 1'b0 || en_reg !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_out: got req=%b en=%b expected 0/0", imem_req, en_reg); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_wait_addr: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
        $display("reset mid-wait: addr=%h", imem_addr);
    endtask

    task automatic test_wrap();
        drive(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h1234_5678);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC || en_reg !== 1'b1 || pc_out !== 32'h0 || ins_out !== 32'h1234_5678) begin
            n_fail++; $display("FAIL wrap: got addr=%h en=%b pc=%h ins=%h expected fffffffc/1/0/12345678", imem_addr, en_reg, pc_out, ins_out); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h expected 0", imem_addr); end
        $display("wrap: next addr=%h", imem_addr);
    endtask

    // Random traffic against a transaction model: program-order fetches,
    // one instruction buffered across stalls, bubbles on redirects, and
    // responses to requests overtaken by a redirect are discarded.
    task automatic test_random();
        logic        busy = 0, stale = 0, buf_valid = 0;
        logic [31:0] maddr = 0, exp_addr = 0, buf_ins = 0, buf_pc = 0;
        int          rem = 0;
        logic        s, rd, ack, exp_en;
        logic [31:0] rpc, d, exp_pc, exp_ins;
        drive(1, 0, 0, 0, 0, 0);
        next_cycle();
        for (int cyc = 0; cyc < 800; cyc++) begin
            s   = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 8);
            rpc = {20'h0, $urandom_range(0, 1023), 2'b00};
            if (!busy && imem_req) begin
                busy = 1; maddr = imem_addr; rem = $urandom_range(0, 3);
            end
            ack = busy && (rem == 0);
            d   = mem_word(maddr);
            drive(0, s, rd, rpc, ack, ack ? d : 32'hX);

            n_cmp++; if (imem_req !== !buf_valid) begin
                n_fail++; $display("FAIL rnd_req c%0d: got %b expected %b", cyc, imem_req, !buf_valid); end
            if (busy) begin
                n_cmp++; if (imem_addr !== maddr) begin
                    n_fail++; $display("FAIL rnd_addr_stable c%0d: got %h expected %h", cyc, imem_addr, maddr); end
            end
            if (ack && !stale && !rd) begin
                n_cmp++; if (maddr !== exp_addr) begin
                    n_fail++; $display("FAIL rnd_fetch_addr c%0d: got %h expected %h", cyc, maddr, exp_addr); end
            end
            exp_pc = 0; exp_ins = 0;
            if (rd) exp_en = 1;
            else if (buf_valid) begin exp_en = !s; exp_pc = buf_pc; exp_ins = buf_ins; end
            else if (ack && !stale && !s) begin exp_en = 1; exp_pc = maddr + 4; exp_ins = d; end
            else exp_en = 0;
            n_cmp++; if (en_reg !== exp_en) begin
                n_fail++; $display("FAIL rnd_en c%0d: got %b expected %b", cyc, en_reg, exp_en); end
            if (exp_en) begin
                n_cmp++; if (pc_out !== exp_pc || ins_out !== exp_ins) begin
                    n_fail++; $display("FAIL rnd_write c%0d: got pc=%h ins=%h expected pc=%h ins=%h", cyc, pc_out, ins_out, exp_pc, exp_ins); end
            end

            if (rd) begin
                exp_addr = rpc; buf_valid = 0; stale = busy && !ack;
            end else if (ack) begin
                if (stale) stale = 0;
                else begin
                    exp_addr = maddr + 4;
                    if (s) begin buf_valid = 1; buf_ins = d; buf_pc = maddr + 4; end
                end
            end else if (buf_valid && !s) begin
                buf_valid = 0;
            end
            if (ack) busy = 0;
            else if (busy) rem--;
            next_cycle();
        end
        $display("random: 800 cycles done, %0d compared so far", n_cmp);
    endtask

    initial begin
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_data = 0;
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_stall();
        next_cycle();
        test_redirect_ack();
        test_redirect_wait();
        test_redirect_hold();
        test_reset_wait();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
